gpsreceiver2_packer: RTL and testbench
======================================

GPSRECEIVER2_PACKER -- requirements
Module: gpsreceiver2_packer

Interface
REQ-001 SHALL have parameter ADR_W, default 11, the byte-address width of the sample buffer (depth 2^ADR_W bytes).
REQ-002 SHALL have port sys_clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port sys_rst, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have port sample_stb, input, 1, qualifies one front-end sample bit; it may be high on consecutive cycles.
REQ-005 SHALL have port sample_bit, input, 1, the sample bit, valid when sample_stb=1.
REQ-006 SHALL have port sample_sync, input, 1, the epoch marker, valid when sample_stb=1.
REQ-007 SHALL have port enable, input, 1, capture enable (level).
REQ-008 SHALL have port clear, input, 1, a one-cycle pulse that zeroes the address, count and flags.
REQ-009 SHALL have port half_ack, input, 2, a one-cycle pulse per bit that acknowledges buffer half [0]=lower or [1]=upper.
REQ-010 SHALL have port rxb_dat, output, 8, the packed byte written to the buffer.
REQ-011 SHALL have port rxb_adr, output, ADR_W, the buffer write address.
REQ-012 SHALL have port rxb_we, output, 1, the buffer write strobe.
REQ-013 SHALL have port rx_count, output, ADR_W, the number of bytes written since the last clear, modulo 2^ADR_W.
REQ-014 SHALL have port half_pending, output, 2, per-half "full, not yet acknowledged" flags.
REQ-015 SHALL have port overflow, output, 1, a sticky overrun flag.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT_SYNC and PACK.
REQ-017 SHALL go IDLE->WAIT_SYNC when enable=1 (under the macro of REQ-030), WAIT_SYNC->PACK on a sample_stb with sample_sync=1, and any state->IDLE when enable=0.
REQ-018 SHALL, in PACK, shift sample_bit LSB-first (first bit to bit 0) on each sample_stb; the sync-qualifying sample is bit 0 of the first byte.
REQ-019 SHALL, on the 8th bit, assert rxb_we for exactly one cycle in the next cycle, with rxb_dat = the byte and rxb_adr = the current address.
REQ-020 SHALL increment rxb_adr and rx_count in the cycle after each write; the address wraps from 2^ADR_W-1 to 0.
REQ-021 SHALL sustain back-to-back bytes when sample_stb is continuous, with no bit lost.
REQ-022 SHALL set half_pending[0] when the byte at address 2^(ADR_W-1)-1 is written, and set half_pending[1] when the byte at address 2^ADR_W-1 is written.
REQ-023 SHALL clear half_pending[i] on half_ack[i]; if set and ack coincide in the same cycle, set wins.
REQ-024 SHALL set overflow when a half completes while its half_pending bit is already 1; overflow is cleared only by clear or reset; writing continues (overwrite).
REQ-025 SHALL, when enable falls mid-byte, discard the partial byte; the address and count are retained.
REQ-026 SHALL, on clear, zero the address, count, half_pending, overflow and the bit counter, and go to IDLE; clear takes priority over a simultaneous write, enable or ack.

Reset
REQ-027 SHALL, while sys_rst=0, put the FSM in IDLE and hold rxb_dat=0, rxb_adr=0, rxb_we=0, rx_count=0, half_pending=0 and overflow=0.
REQ-028 SHALL, when reset is asserted mid-byte or mid-write, suppress any pending rxb_we.

Configuration
REQ-029 SHALL use the macro GPSRECEIVER2_SYNC_ALIGN_EN.
REQ-030 SHALL, with the macro defined, enter WAIT_SYNC on enable and start packing at the sync sample; without it, go IDLE->PACK directly on enable, ignore sample_sync, and omit WAIT_SYNC.

Verification
REQ-031 SHALL cover: macro defined, enable=1, 3 strobes with sync=0, then sync=1 followed by bits 1,0,1,1,0,0,1,0 -> exactly one write, rxb_dat=0x4D at rxb_adr=0, one cycle after the 8th strobe.
REQ-032 SHALL cover: continuous sample_stb for 2048 bytes (ADR_W=11) -> half_pending[0] set after byte 1023, half_pending[1] after byte 2047, rxb_adr wraps to 0, rx_count=0, overflow=0.
REQ-033 SHALL cover: no half_ack, 3072 bytes -> overflow=1 at byte 3071; a subsequent clear -> all flags and rx_count=0.
REQ-034 SHALL cover: enable dropped after 5 bits of byte 2, then re-enabled with a new sync -> no write of the partial byte; the next byte lands at rxb_adr=2.
REQ-035 SHALL cover: half_ack[0] in the same cycle half_pending[0] sets -> the flag stays 1; sys_rst=0 one cycle after the 8th strobe -> no rxb_we and all outputs at 0.

Source files
------------

// File: rtl/gpsreceiver2_packer.sv
`default_nettype none
// ============================================================================
// gpsreceiver2_packer
//   Packs front-end sample bits LSB-first into bytes and writes them to a
//   two-half sample buffer with per-half full flags and a sticky overrun.
//   Optional sync alignment: GPSRECEIVER2_SYNC_ALIGN_EN
//   Rev 1.0 - initial release
// ============================================================================
module gpsreceiver2_packer #(
    parameter int ADR_W = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sample_stb,
    input  logic             sample_bit,
    input  logic             sample_sync,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       half_ack,
    output logic [7:0]       rxb_dat,
    output logic [ADR_W-1:0] rxb_adr,
    output logic             rxb_we,
    output logic [ADR_W-1:0] rx_count,
    output logic [1:0]       half_pending,
    output logic             overflow
);

    localparam logic [ADR_W-1:0] c_LO_LAST = {1'b0, {(ADR_W-1){1'b1}}};
    localparam logic [ADR_W-1:0] c_HI_LAST = {ADR_W{1'b1}};

`ifdef GPSRECEIVER2_SYNC_ALIGN_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SYNC = 2'd1,
        S_PACK      = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd2
    } state_t;
    logic w_unused_sync;
    assign w_unused_sync = sample_sync;
`endif

    state_t           r_state;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_dat;
    logic             r_we;
    logic [ADR_W-1:0] r_adr;
    logic [ADR_W-1:0] r_count;
    logic [1:0]       r_pend;
    logic             r_ovf;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_dat    <= 8'd0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_count  <= '0;
            r_pend   <= 2'b00;
            r_ovf    <= 1'b0;
        end else if (clear) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_count  <= '0;
            r_pend   <= 2'b00;
            r_ovf    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_pend <= r_pend & ~half_ack;

            // Bookkeeping for the byte on the bus this cycle; set beats ack.
            if (r_we) begin
                r_adr   <= r_adr + 1'b1;
                r_count <= r_count + 1'b1;
                if (r_adr == c_LO_LAST) begin
                    r_pend[0] <= 1'b1;
                    if (r_pend[0]) r_ovf <= 1'b1;
                end
                if (r_adr == c_HI_LAST) begin
                    r_pend[1] <= 1'b1;
                    if (r_pend[1]) r_ovf <= 1'b1;
                end
            end

            if (!enable) begin
                r_state  <= S_IDLE;
                r_bitcnt <= 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_bitcnt <= 3'd0;
`ifdef GPSRECEIVER2_SYNC_ALIGN_EN
                        r_state  <= S_WAIT_SYNC;
`else
                        r_state  <= S_PACK;
`endif
                    end
`ifdef GPSRECEIVER2_SYNC_ALIGN_EN
                    S_WAIT_SYNC: begin
                        if (sample_stb && sample_sync) begin
                            r_shift  <= {sample_bit, r_shift[7:1]};
                            r_bitcnt <= 3'd1;
                            r_state  <= S_PACK;
                        end
                    end
`endif
                    S_PACK: begin
                        if (sample_stb) begin
                            r_shift  <= {sample_bit, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_dat <= {sample_bit, r_shift[7:1]};
                                r_we  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Gate the strobe so a reset landing on a write cycle never reaches the RAM.
    assign rxb_we       = r_we & sys_rst;
    assign rxb_dat      = r_dat;
    assign rxb_adr      = r_adr;
    assign rx_count     = r_count;
    assign half_pending = r_pend;
    assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gpsreceiver2_packer.sv
`default_nettype none
// ============================================================================
// tb_gpsreceiver2_packer
//   Directed self-checking bench for gpsreceiver2_packer (ADR_W = 11).
//   Rev 1.0 - initial release
// ============================================================================
module tb_gpsreceiver2_packer;

    localparam int ADR_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             stb, sbit, ssync, en, clr;
    logic [1:0]       ack;
    logic [7:0]       rxb_dat;
    logic [ADR_W-1:0] rxb_adr, rx_count;
    logic             rxb_we, overflow;
    logic [1:0]       half_pending;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int base;
    logic [7:0] last_dat = 8'd0;
    logic [ADR_W-1:0] last_adr = '0;

    always #5 clk = ~clk;

    gpsreceiver2_packer #(.ADR_W(ADR_W)) u_dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .sample_stb   (stb),
        .sample_bit   (sbit),
        .sample_sync  (ssync),
        .enable       (en),
        .clear        (clr),
        .half_ack     (ack),
        .rxb_dat      (rxb_dat),
        .rxb_adr      (rxb_adr),
        .rxb_we       (rxb_we),
        .rx_count     (rx_count),
        .half_pending (half_pending),
        .overflow     (overflow)
    );

    always @(posedge clk) begin
        if (rxb_we) begin
            wr_cnt   <= wr_cnt + 1;
            last_dat <= rxb_dat;
            last_adr <= rxb_adr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        stb = 1'b1; sbit = b; ssync = s;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v, input logic first_sync);
        for (int i = 0; i < 8; i++) send_bit(v[i], first_sync && (i == 0));
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [31:0] t;
        t = i * 7 + 3;
        return t[7:0];
    endfunction

    // From IDLE with enable high: reach the packing point; in sync-aligned
    // builds also feed a few unsynchronised strobes that must be ignored.
    task automatic start_capture();
        en = 1'b1; stb = 1'b0;
        tick();
`ifdef GPSRECEIVER2_SYNC_ALIGN_EN
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
`endif
    endtask

    initial begin
        rst = 1'b0; stb = 1'b0; sbit = 1'b0; ssync = 1'b0;
        en = 1'b0; clr = 1'b0; ack = 2'b00;
        repeat (3) tick();
        chk("rst_we",   rxb_we, 0);
        chk("rst_dat",  rxb_dat, 0);
        chk("rst_adr",  rxb_adr, 0);
        chk("rst_cnt",  rx_count, 0);
        chk("rst_half", half_pending, 0);
        chk("rst_ovf",  overflow, 0);
        rst = 1'b1;
        tick();

        // First byte 0x4D at address 0, one cycle after the 8th strobe
        start_capture();
        send_byte(8'h4D, 1'b1);
        chk("b0_we",  rxb_we, 1);
        chk("b0_dat", rxb_dat, 8'h4D);
        chk("b0_adr", rxb_adr, 0);
        stb = 1'b0;
        tick();
        chk("b0_we_off", rxb_we, 0);
        chk("b0_adr_inc", rxb_adr, 1);
        chk("b0_cnt", rx_count, 1);
        chk("b0_writes", wr_cnt, 1);

        // Second byte, then drop enable after 5 bits of the third
        send_byte(8'hA5, 1'b0);
        chk("b1_dat", rxb_dat, 8'hA5);
        chk("b1_adr", rxb_adr, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        en = 1'b0; stb = 1'b0;
        tick(); tick();
        chk("drop_writes", wr_cnt, 2);
        chk("drop_adr", rxb_adr, 2);
        chk("drop_cnt", rx_count, 2);
        start_capture();
        send_byte(8'h3C, 1'b1);
        chk("resync_we",  rxb_we, 1);
        chk("resync_dat", rxb_dat, 8'h3C);
        chk("resync_adr", rxb_adr, 2);
        stb = 1'b0;
        tick();
        chk("resync_writes", wr_cnt, 3);

        // Clear, then 3072 continuous bytes with no acknowledge
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_adr", rxb_adr, 0);
        chk("clr_cnt", rx_count, 0);
        base = wr_cnt;
        start_capture();
        for (int i = 0; i < 1024; i++) send_byte(pat(i), i == 0);
        chk("h0_adr",  rxb_adr, 1023);
        chk("h0_dat",  rxb_dat, pat(1023));
        chk("h0_pend_before", half_pending, 2'b00);
        send_byte(pat(1024), 1'b0);
        chk("h0_pend", half_pending, 2'b01);
        chk("h0_cnt",  rx_count, 1024);
        for (int i = 1025; i < 2048; i++) send_byte(pat(i), 1'b0);
        chk("h1_adr", rxb_adr, 2047);
        chk("h1_pend_before", half_pending, 2'b01);
        stb = 1'b0;
        tick();
        chk("h1_pend", half_pending, 2'b11);
        chk("wrap_adr", rxb_adr, 0);
        chk("wrap_cnt", rx_count, 0);
        chk("wrap_ovf", overflow, 0);
        chk("wrap_writes", wr_cnt - base, 2048);
        chk("wrap_last_adr", last_adr, 2047);
        chk("wrap_last_dat", last_dat, pat(2047));
        for (int i = 2048; i < 3072; i++) send_byte(pat(i), 1'b0);
        chk("ovf_before", overflow, 0);
        stb = 1'b0;
        tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_adr", rxb_adr, 1024);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr_flag", overflow, 0);
        chk("ovf_clr_half", half_pending, 0);
        chk("ovf_clr_cnt",  rx_count, 0);
        chk("ovf_clr_adr",  rxb_adr, 0);

        // Acknowledge coinciding with the lower half completing
        start_capture();
        for (int i = 0; i < 1024; i++) send_byte(pat(i), i == 0);
        chk("ack_adr", rxb_adr, 1023);
        stb = 1'b0; ack = 2'b01;
        tick();
        ack = 2'b00;
        chk("ack_set_wins", half_pending, 2'b01);
        ack = 2'b01;
        tick();
        ack = 2'b00;
        chk("ack_clears", half_pending, 2'b00);

        // Reset one cycle after the 8th strobe must kill the write
        send_byte(8'hE7, 1'b0);
        base = wr_cnt;
        rst = 1'b0; stb = 1'b0;
        #1;
        chk("rstw_we_gated", rxb_we, 0);
        tick();
        chk("rstw_writes", wr_cnt - base, 0);
        chk("rstw_we",   rxb_we, 0);
        chk("rstw_dat",  rxb_dat, 0);
        chk("rstw_adr",  rxb_adr, 0);
        chk("rstw_cnt",  rx_count, 0);
        chk("rstw_half", half_pending, 0);
        chk("rstw_ovf",  overflow, 0);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
